nios_cross_trigger_ctrl: RTL and testbench

Multicore debug cross-trigger controller for the Nios II group. When any core enters debug mode (debugack high), it requests a break on every other core and waits until all cores are halted. It then holds the group halted until the host issues a resume, and sequences a synchronised release. It sits in sysclk domain beside the per-core JTAG debug modules and drives their break request inputs.

---
 rtl/nios_cross_trigger_ctrl_if.sv | 28 ++
 rtl/nios_cross_trigger_ctrl.sv | 132 +++++++++++++
 tb/tb_nios_cross_trigger_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/nios_cross_trigger_ctrl_if.sv
// Debug cross-trigger bundle between the host/debug side and the controller.
// master: drives arming, per-core debugack status and host commands; observes
//         break requests and status.
// slave : the cross-trigger controller.
interface nios_cross_trigger_ctrl_if #(
    parameter int unsigned NUM_CORES = 4
);
    logic                 enable;
    logic [NUM_CORES-1:0] debugack;
    logic                 resume_req;
    logic                 clear_err;
    logic [NUM_CORES-1:0] break_req;
    logic                 resume_pulse;
    logic                 halted;
    logic [NUM_CORES-1:0] halt_origin;
    logic                 timeout_err;
    logic [1:0]           state;

    modport master (
        output enable, debugack, resume_req, clear_err,
        input  break_req, resume_pulse, halted, halt_origin, timeout_err, state
    );

    modport slave (
        input  enable, debugack, resume_req, clear_err,
        output break_req, resume_pulse, halted, halt_origin, timeout_err, state
    );
endinterface

// File: rtl/nios_cross_trigger_ctrl.sv
// Multicore debug cross-trigger controller. When any armed core enters debug,
// all other cores are asked to break; the group is held halted until the host
// resumes, after which a single release strobe is issued.
// Ports: clk, reset (sync, active-high), dbg (slave modport):
//   in : enable, debugack[NUM_CORES], resume_req, clear_err
//   out: break_req[NUM_CORES], resume_pulse, halted, halt_origin[NUM_CORES],
//        timeout_err, state[2]
// All outputs are registered.
module nios_cross_trigger_ctrl #(
    parameter int unsigned NUM_CORES  = 4,
    parameter int unsigned TMO_W      = 8,
    parameter int unsigned TMO_CYCLES = 200
) (
    input  logic                       clk,
    input  logic                       reset,
    nios_cross_trigger_ctrl_if.slave   dbg
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HALTING  = 2'd1,
        ST_HALTED   = 2'd2,
        ST_RESUMING = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [TMO_W-1:0]     cnt_q, cnt_d;
    logic [NUM_CORES-1:0] break_req_q, break_req_d;
    logic [NUM_CORES-1:0] halt_origin_q, halt_origin_d;
    logic                 resume_pulse_q, resume_pulse_d;
    logic                 halted_q, halted_d;
    logic                 timeout_err_q, timeout_err_d;
    logic                 timeout_set;
    logic                 all_ack, any_ack;

    assign all_ack = &dbg.debugack;
    assign any_ack = |dbg.debugack;

    // Next-state and registered-output logic
    always_comb begin
        state_d       = state_q;
        halt_origin_d = halt_origin_q;
        timeout_set   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (dbg.enable && any_ack) begin
                    state_d       = ST_HALTING;
                    halt_origin_d = dbg.debugack;
                end
            end
            ST_HALTING: begin
                if (all_ack) begin
                    state_d = ST_HALTED;
                end else if (cnt_q == TMO_LAST) begin
                    timeout_set = 1'b1;
                    state_d     = ST_HALTED;
                end
            end
            ST_HALTED: begin
                if (dbg.resume_req) begin
                    state_d = ST_RESUMING;
                end
            end
            ST_RESUMING: begin
                if (!any_ack) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == TMO_LAST) begin
                    timeout_set = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Requests only while staying in HALTING, so they read 0 on every entry.
        break_req_d    = (state_q == ST_HALTING && state_d == ST_HALTING)
                         ? ~dbg.debugack : '0;
        resume_pulse_d = (state_q == ST_HALTED) && (state_d == ST_RESUMING);
        halted_d       = (state_d == ST_HALTED) && all_ack;

        // A new timeout takes precedence over a simultaneous clear.
        if (timeout_set) begin
            timeout_err_d = 1'b1;
        end else if (dbg.clear_err) begin
            timeout_err_d = 1'b0;
        end else begin
            timeout_err_d = timeout_err_q;
        end

        // Counter restarts on any state change and saturates at all-ones.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if ((state_q == ST_HALTING || state_q == ST_RESUMING)
                     && (cnt_q != '1)) begin
            cnt_d = cnt_q + TMO_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            break_req_q    <= '0;
            halt_origin_q  <= '0;
            resume_pulse_q <= 1'b0;
            halted_q       <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            break_req_q    <= break_req_d;
            halt_origin_q  <= halt_origin_d;
            resume_pulse_q <= resume_pulse_d;
            halted_q       <= halted_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

    assign dbg.break_req    = break_req_q;
    assign dbg.resume_pulse = resume_pulse_q;
    assign dbg.halted       = halted_q;
    assign dbg.halt_origin  = halt_origin_q;
    assign dbg.timeout_err  = timeout_err_q;
    assign dbg.state        = state_q;

endmodule

// File: tb/tb_nios_cross_trigger_ctrl.sv
// Scoreboard bench: stimulus pushes expected output snapshots tagged with the
// cycle they must appear in; a monitor on the falling edge pops and compares.
module tb_nios_cross_trigger_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nios_cross_trigger_ctrl_if #(.NUM_CORES(4)) dbg ();

    nios_cross_trigger_ctrl #(
        .NUM_CORES (4),
        .TMO_W     (8),
        .TMO_CYCLES(200)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .dbg  (dbg.slave)
    );

    typedef struct {
        int         at;
        string      name;
        logic [1:0] st;
        logic [3:0] br;
        logic       hl;
        logic [3:0] ho;
        logic       te;
        logic       rp;
    } exp_t;

    exp_t q[$];
    int   pq[$];
    exp_t e;

    task automatic ex(input int at, input string nm, input logic [1:0] st,
                      input logic [3:0] br, input logic hl, input logic [3:0] ho,
                      input logic te, input logic rp);
        exp_t x;
        x.at = at; x.name = nm; x.st = st; x.br = br;
        x.hl = hl; x.ho = ho; x.te = te; x.rp = rp;
        q.push_back(x);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compare scheduled snapshots and every resume strobe
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].at <= cyc) begin
            e = q.pop_front();
            checks++;
            if (e.at != cyc || dbg.state !== e.st || dbg.break_req !== e.br ||
                dbg.halted !== e.hl || dbg.halt_origin !== e.ho ||
                dbg.timeout_err !== e.te || dbg.resume_pulse !== e.rp) begin
                errors++;
                $display("FAIL %s cyc=%0d(at %0d): got st=%0d br=%b hl=%b ho=%b te=%b rp=%b, exp st=%0d br=%b hl=%b ho=%b te=%b rp=%b",
                         e.name, cyc, e.at, dbg.state, dbg.break_req, dbg.halted,
                         dbg.halt_origin, dbg.timeout_err, dbg.resume_pulse,
                         e.st, e.br, e.hl, e.ho, e.te, e.rp);
            end
        end
        if (dbg.resume_pulse === 1'b1) begin
            checks++;
            if (pq.size() == 0 || pq[0] != cyc) begin
                errors++;
                $display("FAIL resume_pulse: strobe at cyc=%0d, expected at %0d",
                         cyc, (pq.size() == 0) ? -1 : pq[0]);
            end
            if (pq.size() > 0) void'(pq.pop_front());
        end
    end

    int t, s, u, w, x, y;

    initial begin
        reset = 1'b1;
        dbg.enable = 1'b0;
        dbg.debugack = 4'b0000;
        dbg.resume_req = 1'b0;
        dbg.clear_err = 1'b0;
        step(3);
        ex(cyc, "reset", 0, 4'b0000, 0, 4'b0000, 0, 0);
        reset = 1'b0;
        step(7);

        // Single-core trigger, then all cores ack
        t = cyc;
        dbg.enable = 1'b1;
        dbg.debugack = 4'b0001;
        ex(t+1, "trig", 1, 4'b0000, 0, 4'b0001, 0, 0);
        ex(t+2, "brk", 1, 4'b1110, 0, 4'b0001, 0, 0);
        ex(t+5, "brk_hold", 1, 4'b1110, 0, 4'b0001, 0, 0);
        step(5);
        dbg.debugack = 4'b1111;
        ex(t+6, "halted", 2, 4'b0000, 1, 4'b0001, 0, 0);
        ex(t+7, "halted_hold", 2, 4'b0000, 1, 4'b0001, 0, 0);
        step(3);

        // Resume; cores leave debug 5 cycles later
        s = cyc;
        dbg.resume_req = 1'b1;
        pq.push_back(s+1);
        ex(s+1, "rpulse", 3, 4'b0000, 0, 4'b0001, 0, 1);
        step(1);
        dbg.resume_req = 1'b0;
        ex(s+2, "resuming", 3, 4'b0000, 0, 4'b0001, 0, 0);
        step(4);
        dbg.debugack = 4'b0000;
        ex(s+6, "resumed_idle", 0, 4'b0000, 0, 4'b0001, 0, 0);
        step(3);
        dbg.resume_req = 1'b1;
        ex(cyc+1, "rreq_idle", 0, 4'b0000, 0, 4'b0001, 0, 0);
        step(1);
        dbg.resume_req = 1'b0;
        step(2);

        // Simultaneous origins; core 3 never acks -> halt timeout
        u = cyc;
        dbg.debugack = 4'b0101;
        ex(u+1, "sim_trig", 1, 4'b0000, 0, 4'b0101, 0, 0);
        ex(u+2, "sim_brk", 1, 4'b1010, 0, 4'b0101, 0, 0);
        step(2);
        dbg.debugack = 4'b0111;
        ex(u+3, "core3", 1, 4'b1000, 0, 4'b0101, 0, 0);
        step(1);
        dbg.debugack = 4'b0011;
        ex(u+4, "redrop", 1, 4'b1100, 0, 4'b0101, 0, 0);
        step(1);
        dbg.debugack = 4'b0111;
        ex(u+5, "core3b", 1, 4'b1000, 0, 4'b0101, 0, 0);
        ex(u+200, "pre_tmo", 1, 4'b1000, 0, 4'b0101, 0, 0);
        ex(u+201, "halt_tmo", 2, 4'b0000, 0, 4'b0101, 1, 0);
        step(u + 202 - cyc);
        dbg.clear_err = 1'b1;
        ex(u+203, "clr", 2, 4'b0000, 0, 4'b0101, 0, 0);
        step(1);
        dbg.clear_err = 1'b0;
        dbg.debugack = 4'b1111;
        ex(cyc+1, "halted_upd", 2, 4'b0000, 1, 4'b0101, 0, 0);
        step(2);

        // Resume with cores stuck in debug -> resume timeout, clear loses, re-halt
        w = cyc;
        dbg.resume_req = 1'b1;
        pq.push_back(w+1);
        ex(w+1, "rp2", 3, 4'b0000, 0, 4'b0101, 0, 1);
        step(1);
        dbg.resume_req = 1'b0;
        ex(w+200, "pre_rtmo", 3, 4'b0000, 0, 4'b0101, 0, 0);
        step(w + 200 - cyc);
        dbg.clear_err = 1'b1;
        ex(w+201, "rtmo_setwins", 0, 4'b0000, 0, 4'b0101, 1, 0);
        step(1);
        dbg.clear_err = 1'b0;
        ex(w+202, "retrig", 1, 4'b0000, 0, 4'b1111, 1, 0);
        ex(w+203, "rehalt", 2, 4'b0000, 1, 4'b1111, 1, 0);
        step(2);
        dbg.clear_err = 1'b1;
        ex(w+204, "clr2", 2, 4'b0000, 1, 4'b1111, 0, 0);
        step(1);
        dbg.clear_err = 1'b0;

        x = cyc;
        dbg.resume_req = 1'b1;
        pq.push_back(x+1);
        ex(x+1, "rp3", 3, 4'b0000, 0, 4'b1111, 0, 1);
        step(1);
        dbg.resume_req = 1'b0;
        step(1);
        dbg.debugack = 4'b0000;
        ex(x+3, "idle3", 0, 4'b0000, 0, 4'b1111, 0, 0);
        step(2);

        // Disarmed: debugack ignored until enable rises
        y = cyc;
        dbg.enable = 1'b0;
        dbg.debugack = 4'b0010;
        ex(y+1, "dis1", 0, 4'b0000, 0, 4'b1111, 0, 0);
        ex(y+2, "dis2", 0, 4'b0000, 0, 4'b1111, 0, 0);
        step(3);
        dbg.enable = 1'b1;
        ex(y+4, "en_trig", 1, 4'b0000, 0, 4'b0010, 0, 0);
        ex(y+5, "en_brk", 1, 4'b1101, 0, 4'b0010, 0, 0);
        step(2);
        dbg.debugack = 4'b0011;
        ex(y+6, "br1100", 1, 4'b1100, 0, 4'b0010, 0, 0);
        step(1);

        // Reset mid-HALTING, then immediate re-trigger
        reset = 1'b1;
        ex(y+7, "rst_mid", 0, 4'b0000, 0, 4'b0000, 0, 0);
        step(1);
        reset = 1'b0;
        ex(y+8, "post_rst_trig", 1, 4'b0000, 0, 4'b0011, 0, 0);
        step(1);
        dbg.enable = 1'b0;
        ex(y+9, "en_off_halting", 1, 4'b1100, 0, 4'b0011, 0, 0);
        step(1);
        dbg.debugack = 4'b1111;
        ex(y+10, "final_halt", 2, 4'b0000, 1, 4'b0011, 0, 0);
        step(3);

        // Nothing may remain unchecked
        checks++;
        if (q.size() != 0 || pq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d snapshots and %0d strobes left, expected 0 and 0",
                     q.size(), pq.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
